// File: rtl/cla8_word_sequencer_if.sv
// cla8_word_sequencer_if
// Bundles the request handshake, the result handshake and the shared
// 8-bit carry-lookahead slice connection of cla8_word_sequencer.
//   Request : in_valid, in_ready, op_a[W], op_b[W], sub
//   Result  : out_valid, out_ready, result[W], carry_out, overflow, zero, busy
//   Slice   : slice_a[8], slice_b[8], slice_cin  -> external slice
//             slice_sum[8], slice_gout, slice_pout <- external slice
// The slave modport is the sequencer's view; the master modport is the view
// of the surrounding datapath (requester, consumer and the slice itself).
interface cla8_word_sequencer_if #(
  parameter int SLICES = 4
);
  localparam int W = 8 * SLICES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  logic [7:0]   slice_a;
  logic [7:0]   slice_b;
  logic         slice_cin;
  logic [7:0]   slice_sum;
  logic         slice_gout;
  logic         slice_pout;

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    input  slice_sum, slice_gout, slice_pout,
    output in_ready, out_valid, result, carry_out, overflow, zero, busy,
    output slice_a, slice_b, slice_cin
  );

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    output slice_sum, slice_gout, slice_pout,
    input  in_ready, out_valid, result, carry_out, overflow, zero, busy,
    input  slice_a, slice_b, slice_cin
  );
endinterface

// File: rtl/cla8_word_sequencer.sv
// cla8_word_sequencer
// Performs a W = 8*SLICES bit add or subtract by pushing one byte per cycle,
// LSB first, through a single external 8-bit carry-lookahead slice. The
// inter-byte carry is kept in a register and the result is assembled byte by
// byte. A request accepted at edge E presents out_valid after edge E+SLICES.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : cla8_word_sequencer_if.slave (request, result and slice signals)
// SLICES must match the SLICES parameter of the connected interface (2..8).
module cla8_word_sequencer #(
  parameter int SLICES = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  cla8_word_sequencer_if.slave bus
);

  localparam int W     = 8 * SLICES;
  localparam int IDX_W = $clog2(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     bEff_q;
  logic [W-1:0]     result_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             carryOut_q;
  logic             overflow_q;
  logic             zero_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             busy_q;

  logic [IDX_W+2:0] bitBase;
  logic             carry_d;
  logic [W-1:0]     result_d;
  logic             inRun;

  // Bit offset of the byte currently being processed.
  assign bitBase = {idx_q, 3'b000};
  assign inRun   = (state_q == RUN);

  // Carry into the next byte and the result as it looks once the current
  // slice sum has been merged in. The zero flag is taken from the merged
  // value so the last byte counts in the same cycle it is produced.
  always_comb begin
    carry_d  = bus.slice_gout | (bus.slice_pout & carry_q);
    result_d = result_q;
    result_d[bitBase +: 8] = bus.slice_sum;
  end

  // The slice only sees operands while running; it is parked at zero otherwise.
  assign bus.slice_a   = inRun ? a_q[bitBase +: 8]    : 8'h00;
  assign bus.slice_b   = inRun ? bEff_q[bitBase +: 8] : 8'h00;
  assign bus.slice_cin = inRun ? carry_q              : 1'b0;

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carryOut_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Control FSM with all handshake outputs registered alongside the state.
  // Subtraction is done as A + ~B + 1: B is inverted at acceptance and the
  // +1 enters through the initial carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      bEff_q     <= '0;
      result_q   <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady_q) begin
            a_q       <= bus.op_a;
            bEff_q    <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q   <= bus.sub;
            idx_q     <= '0;
            state_q   <= RUN;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            carryOut_q <= carry_d;
            // Operands of equal sign producing a result of the other sign.
            overflow_q <= (a_q[W-1] == bEff_q[W-1]) &&
                          (bus.slice_sum[7] != a_q[W-1]);
            zero_q     <= (result_d == '0);
            idx_q      <= '0;
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end

        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla8_word_sequencer.sv
// tb_cla8_word_sequencer
// Self-checking bench for cla8_word_sequencer with SLICES=4. Provides a
// behavioural 8-bit lookahead slice, issues directed and random requests,
// and checks results through a scoreboard popped by an independent monitor.
module tb_cla8_word_sequencer;

  localparam int SLICES   = 4;
  localparam int W        = 8 * SLICES;
  localparam int MAX_WAIT = 50;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           acceptCycle;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   cycle       = 0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   lastAccept  = 0;
  int   prevAccept  = 0;
  exp_t sbq[$];
  logic [8:0] sliceRaw;

  cla8_word_sequencer_if #(.SLICES(SLICES)) bus ();

  cla8_word_sequencer #(.SLICES(SLICES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock and a cycle counter used for latency measurements.
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // Behavioural 8-bit lookahead slice: generate is the carry out with no
  // carry in, propagate is true when every bit position propagates.
  assign sliceRaw       = {1'b0, bus.slice_a} + {1'b0, bus.slice_b};
  assign bus.slice_gout = sliceRaw[8];
  assign bus.slice_pout = &(bus.slice_a ^ bus.slice_b);
  assign bus.slice_sum  = sliceRaw[7:0] + {7'b0, bus.slice_cin};

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference result from plain integer arithmetic on the whole word.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
    exp_t e;
    longint unsigned ua, ub, full;
    longint sa, sb, sv, maxPos, minNeg;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    maxPos = (longint'(1) <<< (W - 1)) - 1;
    minNeg = -(longint'(1) <<< (W - 1));
    if (s) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sv   = sa - sb;
    end else begin
      full = ua + ub;
      e.c  = (full >= (64'd1 << W));
      sv   = sa + sb;
    end
    e.res = full[W-1:0];
    e.z   = (e.res == '0);
    e.v   = (sv > maxPos) || (sv < minNeg);
    e.acceptCycle = 0;
    return e;
  endfunction

  // Carry entering byte k: whether the low 8k bits overflow (add) or do not
  // borrow (subtract).
  function automatic logic expCin(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input int k);
    longint unsigned m, al, bl;
    if (k == 0) return s;
    m  = (64'd1 << (8 * k)) - 1;
    al = a & m;
    bl = b & m;
    if (s) return al >= bl;
    return (al + bl) > m;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Present a request, wait (bounded) for acceptance and push its expectation.
  // Returns #1 after the acceptance edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
    int   waited;
    exp_t e;
    waited = 0;
    @(posedge clock); #1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < MAX_WAIT) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    e = model(a, b, s);
    e.acceptCycle = cycle;
    sbq.push_back(e);
    prevAccept   = lastAccept;
    lastAccept   = cycle;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.sub      = 1'($urandom_range(0, 1));
  endtask

  // Check what the slice is fed in each RUN cycle; optionally wave new
  // requests at the block while it is busy. Returns #1 after the last edge.
  task automatic checkRun(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic poke);
    logic [W-1:0] bEff;
    bEff = s ? ~b : b;
    for (int k = 0; k < SLICES; k++) begin
      checkOutput("sliceA", bus.slice_a, a[8*k +: 8]);
      checkOutput("sliceB", bus.slice_b, bEff[8*k +: 8]);
      checkOutput("sliceCin", bus.slice_cin, expCin(a, b, s, k));
      checkOutput("busyRun", bus.busy, 1);
      checkOutput("inReadyRun", bus.in_ready, 0);
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.sub      = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    applyStimulus(a, b, s);
    checkRun(a, b, s, 1'b0);
  endtask

  // Scoreboard monitor: measures latency on each rising out_valid and pops
  // the oldest expectation on every result handshake.
  initial begin
    logic prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevValid = 1'b0;
      end else begin
        if (bus.out_valid && !prevValid) begin
          if (sbq.size() == 0)
            checkOutput("unexpectedValid", bus.out_valid, 0);
          else
            checkOutput("latency", cycle - sbq[0].acceptCycle, SLICES);
        end
        if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("result", bus.result, e.res);
          checkOutput("carryOut", bus.carry_out, e.c);
          checkOutput("overflow", bus.overflow, e.v);
          checkOutput("zero", bus.zero, e.z);
        end
        prevValid = bus.out_valid;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rs;
    int waited;

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstInReady", bus.in_ready, 1);
    checkOutput("rstOutValid", bus.out_valid, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstResult", bus.result, 0);
    checkOutput("rstCarry", bus.carry_out, 0);
    checkOutput("rstOverflow", bus.overflow, 0);
    checkOutput("rstZero", bus.zero, 0);
    checkOutput("rstSliceA", bus.slice_a, 0);
    checkOutput("rstSliceCin", bus.slice_cin, 0);
    reset_n = 1'b1;

    // Directed arithmetic corners.
    runOne(32'h000000FF, 32'h00000001, 1'b0);
    runOne(32'hFFFFFFFF, 32'h00000001, 1'b0);
    runOne(32'h00000005, 32'h00000007, 1'b1);
    runOne(32'h80000000, 32'h00000001, 1'b1);

    // Consumer stalls for ten cycles on a signed-overflow result.
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0);
    bus.out_ready = 1'b0;
    checkRun(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    e = model(32'h7FFFFFFF, 32'h00000001, 1'b0);
    repeat (10) begin
      checkOutput("holdValid", bus.out_valid, 1);
      checkOutput("holdInReady", bus.in_ready, 0);
      checkOutput("holdResult", bus.result, e.res);
      checkOutput("holdOverflow", bus.overflow, e.v);
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("releaseInReady", bus.in_ready, 1);
    checkOutput("releaseOutValid", bus.out_valid, 0);
    checkOutput("releaseBusy", bus.busy, 0);

    // New requests waved at the block while it runs must be ignored.
    applyStimulus(32'h12345678, 32'h0F0F0F0F, 1'b0);
    checkRun(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);

    // Back-to-back requests with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      rs = 1'($urandom_range(0, 1));
      runOne(ra, rb, rs);
      if (i > 0) checkOutput("b2bSpacing", lastAccept - prevAccept, SLICES + 2);
    end

    // Reset in the second RUN cycle discards the operation.
    applyStimulus(32'hDEADBEEF, 32'h01020304, 1'b0);
    @(posedge clock); #1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRstInReady", bus.in_ready, 1);
    checkOutput("midRstOutValid", bus.out_valid, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstResult", bus.result, 0);
    checkOutput("midRstCarry", bus.carry_out, 0);
    checkOutput("midRstSliceA", bus.slice_a, 0);
    checkOutput("midRstSliceCin", bus.slice_cin, 0);
    sbq.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    runOne(32'h00001000, 32'h00000001, 1'b1);

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 20; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs);
      bus.out_ready = 1'($urandom_range(0, 1));
      checkRun(ra, rb, rs, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
      bus.out_ready = 1'b1;
    end

    waited = 0;
    while (sbq.size() != 0 && waited < MAX_WAIT) begin
      @(posedge clock); #1;
      waited++;
    end
    checkOutput("drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Last-resort bound on simulation time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
